// File: rtl/dff_bist_checker.sv
// dff_bist_checker: on-chip self-test engine for single-bit storage cells.
// Drives a fixed serial pattern into d and checks q/qbar after a latency.
module dff_bist_checker #(
  parameter logic [15:0] PATTERN = 16'hA5C3,
  parameter int unsigned LEN     = 16,
  parameter int unsigned LATENCY = 1,
  parameter int unsigned ERR_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  output logic             d_out,
  input  logic             q_in,
  input  logic             qbar_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [3:0]       first_err_idx
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DRIVE,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [3:0]       idx_q, idx_d;
  logic [1:0]       drn_q, drn_d;
  logic             d_out_q, d_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic [3:0]       first_q, first_d;

  logic [LATENCY-1:0]      pvld_q, pvld_d;
  logic [LATENCY-1:0]      pbit_q, pbit_d;
  logic [LATENCY-1:0][3:0] pidx_q, pidx_d;

  logic       cmp_vld;
  logic       cmp_exp;
  logic [3:0] cmp_idx;
  logic       cmp_bad;

  // Next-state, stimulus, expected pipeline and result bookkeeping
  always_comb begin
    cmp_vld = pvld_q[LATENCY-1];
    cmp_exp = pbit_q[LATENCY-1];
    cmp_idx = pidx_q[LATENCY-1];
    cmp_bad = cmp_vld &&
              ((q_in != cmp_exp) || (qbar_in == q_in));

    state_d = state_q;
    idx_d   = idx_q;
    drn_d   = drn_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DRIVE;
          idx_d   = 4'd0;
          err_d   = '0;
          first_d = 4'd0;
          pass_d  = 1'b0;
        end
      end
      S_DRIVE: begin
        if (idx_q == 4'(LEN - 1)) begin
          state_d = S_DRAIN;
          drn_d   = 2'd0;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      S_DRAIN: begin
        if (drn_q == 2'(LATENCY - 1)) begin
          state_d = S_DONE;
        end else begin
          drn_d = drn_q + 2'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (cmp_bad) begin
      if (err_q == '0) begin
        first_d = cmp_idx;
      end
      if (err_q != '1) begin
        err_d = err_q + ERR_W'(1);
      end
    end

    if (state_d == S_DONE) begin
      pass_d = (err_d == '0);
    end

    d_out_d = (state_d == S_DRIVE) ? PATTERN[idx_d] : 1'b0;
    busy_d  = (state_d == S_DRIVE) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);

    pvld_d    = pvld_q;
    pbit_d    = pbit_q;
    pidx_d    = pidx_q;
    pvld_d[0] = (state_q == S_DRIVE);
    pbit_d[0] = d_out_q;
    pidx_d[0] = idx_q;
    for (int k = 1; k < LATENCY; k++) begin
      pvld_d[k] = pvld_q[k-1];
      pbit_d[k] = pbit_q[k-1];
      pidx_d[k] = pidx_q[k-1];
    end
  end

  // All state and registered outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= 4'd0;
      drn_q   <= 2'd0;
      d_out_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      first_q <= 4'd0;
      pvld_q  <= '0;
      pbit_q  <= '0;
      pidx_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      drn_q   <= drn_d;
      d_out_q <= d_out_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      first_q <= first_d;
      pvld_q  <= pvld_d;
      pbit_q  <= pbit_d;
      pidx_q  <= pidx_d;
    end
  end

  assign d_out         = d_out_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass          = pass_q;
  assign err_count     = err_q;
  assign first_err_idx = first_q;

endmodule
